tlc_phase_scheduler: RTL and testbench



---
 rtl/tlc_phase_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_tlc_phase_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: timed phase sequencer for a two-street intersection.
// Arbitrates green time between street A, street B and a latched pedestrian
// request. All durations are counted in ticks of an external timebase strobe.
// Optional feature macro: TLC_FLASH_EN adds a 'flash' input and a FLASH
// state (phase=7) with a blinking yellow on street A.
module tlc_phase_scheduler #(
  parameter int MIN_GREEN   = 8,
  parameter int MAX_GREEN   = 32,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 6,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req,
`ifdef TLC_FLASH_EN
  input  logic       flash,
`endif
  output logic       ped_ack,
  output logic       walk,
  output logic       RA,
  output logic       GA,
  output logic       YA,
  output logic       RB,
  output logic       GB,
  output logic       YB,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    GREEN_A  = 3'd0,
    YELLOW_A = 3'd1,
    ALLRED_A = 3'd2,
    GREEN_B  = 3'd3,
    YELLOW_B = 3'd4,
    ALLRED_B = 3'd5,
    WALK     = 3'd6
`ifdef TLC_FLASH_EN
    , FLASH  = 3'd7
`endif
  } state_t;

  typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_t;

  // Terminal counts, truncated to the counter width.
  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ARD_M1 = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] WLK_M1 = CNT_W'(WALK_TIME - 1);

  state_t           state_q, state_d;
  side_t            last_side_q, last_side_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q;
  logic             enter_walk;
  logic             exit_a, exit_b;
`ifdef TLC_FLASH_EN
  logic             flash_ya_q;
`endif

  // Green may end once minimum green is served and the other side (or a
  // pedestrian) wants the road; contested demand is capped at max green.
  assign exit_a = (cnt_q >= MIN_M1) &&
                  (ped_pend_q || (TB && (!TA || (cnt_q == MAX_M1))));
  assign exit_b = (cnt_q >= MIN_M1) &&
                  (ped_pend_q || (TA && (!TB || (cnt_q == MAX_M1))));

  // Next-state, dwell counter and pedestrian latch.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    last_side_d = last_side_q;
    cnt_d       = cnt_q;
    if (tick) begin
      case (state_q)
        GREEN_A:  if (exit_a) state_d = YELLOW_A;
        YELLOW_A: if (cnt_q == YEL_M1) state_d = ALLRED_A;
        ALLRED_A: if (cnt_q == ARD_M1) begin
                    if (ped_pend_q) begin
                      state_d     = WALK;
                      last_side_d = SIDE_A;
                    end else begin
                      state_d = GREEN_B;
                    end
                  end
        GREEN_B:  if (exit_b) state_d = YELLOW_B;
        YELLOW_B: if (cnt_q == YEL_M1) state_d = ALLRED_B;
        ALLRED_B: if (cnt_q == ARD_M1) begin
                    if (ped_pend_q) begin
                      state_d     = WALK;
                      last_side_d = SIDE_B;
                    end else begin
                      state_d = GREEN_A;
                    end
                  end
        WALK:     if (cnt_q == WLK_M1)
                    state_d = (last_side_q == SIDE_A) ? GREEN_B : GREEN_A;
        default:  ;
      endcase
    end
`ifdef TLC_FLASH_EN
    // Flash mode pre-empts everything; leaving it always clears through ALLRED_B.
    if (state_q == FLASH && !flash) state_d = ALLRED_B;
    if (flash)                      state_d = FLASH;
`endif

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if ((state_q == GREEN_A || state_q == GREEN_B) && (cnt_q == MAX_M1))
        cnt_d = cnt_q;
      else
        cnt_d = cnt_q + 1'b1;
    end

    enter_walk = (state_d == WALK) && (state_q != WALK);
    // Requests during WALK are ignored; clearing on WALK entry wins over a set.
    ped_pend_d = ped_pend_q | (ped_req & (state_q != WALK));
    if (enter_walk) ped_pend_d = 1'b0;
`ifdef TLC_FLASH_EN
    if (state_q == FLASH || state_d == FLASH) ped_pend_d = 1'b0;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (rst) begin
      state_q     <= GREEN_A;
      last_side_q <= SIDE_A;
      cnt_q       <= '0;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_side_q <= last_side_d;
      cnt_q       <= cnt_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= enter_walk;
    end
  end

`ifdef TLC_FLASH_EN
  // Blink phase for the flashing yellow; restarts dark on each FLASH entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != FLASH) flash_ya_q <= 1'b0;
    else if (tick)               flash_ya_q <= ~flash_ya_q;
  end
`endif

  // Lamp decode of the registered state.
  always_comb begin
    RA   = 1'b0;
    GA   = 1'b0;
    YA   = 1'b0;
    RB   = 1'b0;
    GB   = 1'b0;
    YB   = 1'b0;
    walk = 1'b0;
    case (state_q)
      GREEN_A:  begin GA = 1'b1; RB = 1'b1; end
      YELLOW_A: begin YA = 1'b1; RB = 1'b1; end
      GREEN_B:  begin RA = 1'b1; GB = 1'b1; end
      YELLOW_B: begin RA = 1'b1; YB = 1'b1; end
      WALK:     begin RA = 1'b1; RB = 1'b1; walk = 1'b1; end
`ifdef TLC_FLASH_EN
      FLASH:    begin YA = flash_ya_q; RB = ~flash_ya_q; end
`endif
      default:  begin RA = 1'b1; RB = 1'b1; end
    endcase
  end

  assign phase   = state_q;
  assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler: directed vector table,
// multi-cycle corner sequences and randomized traffic against a reference model.
module tb_tlc_phase_scheduler;

  localparam int MIN_GREEN   = 8;
  localparam int MAX_GREEN   = 32;
  localparam int YELLOW_TIME = 3;
  localparam int ALLRED_TIME = 2;
  localparam int WALK_TIME   = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash = 1'b0;
  logic       ped_ack, walk, ra, ga, ya, rb, gb, yb;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_en = 1'b1;

  always #5 clk = ~clk;

  tlc_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_TIME(YELLOW_TIME),
    .ALLRED_TIME(ALLRED_TIME), .WALK_TIME(WALK_TIME), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .TA(ta), .TB(tb), .ped_req(ped_req),
`ifdef TLC_FLASH_EN
    .flash(flash),
`endif
    .ped_ack(ped_ack), .walk(walk),
    .RA(ra), .GA(ga), .YA(ya), .RB(rb), .GB(gb), .YB(yb),
    .phase(phase)
  );

  // Lamp pattern {RA,GA,YA,RB,GB,YB,walk} for each phase.
  function automatic logic [6:0] lamps_of(input int p);
    case (p)
      0:       return 7'b0101000;
      1:       return 7'b0011000;
      2:       return 7'b1001000;
      3:       return 7'b1000100;
      4:       return 7'b1000010;
      5:       return 7'b1001000;
      6:       return 7'b1001001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: phase plus elapsed ticks in that phase (unbounded).
  int m_phase = 0;
  int m_ticks = 0;
  bit m_pend  = 1'b0;
  bit m_last_b = 1'b0;
  bit m_ack   = 1'b0;

  always @(posedge clk) begin
    int nxt;
    bit other, own;
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_pend = 0; m_last_b = 0; m_ack = 0;
    end else begin
      nxt = m_phase;
      if (tick) begin
        if (m_phase == 0 || m_phase == 3) begin
          other = (m_phase == 0) ? tb : ta;
          own   = (m_phase == 0) ? ta : tb;
          if (m_ticks >= MIN_GREEN - 1 &&
              (m_pend || (other && (!own || m_ticks >= MAX_GREEN - 1))))
            nxt = m_phase + 1;
        end else if (m_phase == 1 || m_phase == 4) begin
          if (m_ticks == YELLOW_TIME - 1) nxt = m_phase + 1;
        end else if (m_phase == 2 || m_phase == 5) begin
          if (m_ticks == ALLRED_TIME - 1) begin
            if (m_pend) begin nxt = 6; m_last_b = (m_phase == 5); end
            else nxt = (m_phase == 2) ? 3 : 0;
          end
        end else if (m_phase == 6) begin
          if (m_ticks == WALK_TIME - 1) nxt = m_last_b ? 0 : 3;
        end
      end
      m_ack  = (nxt == 6) && (m_phase != 6);
      m_pend = (m_pend || (ped_req && m_phase != 6)) && !m_ack;
      if (nxt != m_phase) m_ticks = 0;
      else if (tick) m_ticks++;
      m_phase = nxt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then compare with the model after the edge.
  task automatic step(input logic r, input logic t, input logic a,
                      input logic b, input logic p);
    rst = r; tick = t; ta = a; tb = b; ped_req = p;
    @(posedge clk); #1;
    if (model_en) begin
      check("model.phase", 32'(phase), 32'(m_phase));
      check("model.lamps", 32'({ra, ga, ya, rb, gb, yb, walk}), 32'(lamps_of(m_phase)));
      check("model.ped_ack", 32'(ped_ack), 32'(m_ack));
    end
  endtask

  typedef struct {
    logic r, t, a, b, p;
    int   n;
    int   exp_phase;
    logic exp_ack;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic t, input logic a, input logic b,
                              input logic p, input int n, input int ph, input logic ack);
    vec_t v;
    v.r = r; v.t = t; v.a = a; v.b = b; v.p = p;
    v.n = n; v.exp_phase = ph; v.exp_ack = ack;
    vecs.push_back(v);
  endfunction

  initial begin
    int first_y, first_ar, first_gb, bad_hold, prev_phase, toggles, rb_bad;
    logic prev_ya;

    // Reset, then B demand only: yellow on edge 8, all-red on 11, green B on 13.
    add(1,0,0,1,0, 1, 0,0);
    add(0,1,0,1,0, 7, 0,0);
    add(0,1,0,1,0, 1, 1,0);
    add(0,1,0,1,0, 2, 1,0);
    add(0,1,0,1,0, 1, 2,0);
    add(0,1,0,1,0, 1, 2,0);
    add(0,1,0,1,0, 1, 3,0);
    add(0,1,0,1,0, 40, 3,0);   // rests on B with no A demand
    add(0,0,1,0,0, 5, 3,0);    // no tick: hold despite A demand
    add(0,1,1,0,0, 1, 4,0);    // min served, A demand: immediate yellow
    add(0,1,1,0,0, 3, 5,0);
    add(0,1,1,0,0, 2, 0,0);
    // Pedestrian pulse at cnt=2: yellow after tick 8, WALK with ack, then green B.
    add(1,0,1,0,0, 1, 0,0);
    add(0,1,1,0,0, 2, 0,0);
    add(0,1,1,0,1, 1, 0,0);
    add(0,1,1,0,0, 4, 0,0);
    add(0,1,1,0,0, 1, 1,0);
    add(0,1,1,0,0, 3, 2,0);
    add(0,1,1,0,0, 2, 6,1);
    add(0,1,1,0,0, 1, 6,0);
    add(0,1,1,0,0, 4, 6,0);
    add(0,1,1,0,0, 1, 3,0);
    // Pedestrian from green B, then reset in the middle of WALK.
    add(0,1,1,0,1, 1, 3,0);
    add(0,1,1,0,0, 6, 3,0);
    add(0,1,1,0,0, 1, 4,0);
    add(0,1,1,0,0, 3, 5,0);
    add(0,1,1,0,0, 2, 6,1);
    add(0,1,1,0,0, 2, 6,0);
    add(1,1,1,0,0, 1, 0,0);
    add(0,1,1,0,0, 20, 0,0);   // no stale ped request after reset
    // Both sides busy: each green maxes out at exactly 32 ticks.
    add(1,0,1,1,0, 1, 0,0);
    add(0,1,1,1,0, 31, 0,0);
    add(0,1,1,1,0, 1, 1,0);
    add(0,1,1,1,0, 5, 3,0);
    add(0,1,1,1,0, 31, 3,0);
    add(0,1,1,1,0, 1, 4,0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].p);
      check($sformatf("vec%0d.phase", i), 32'(phase), 32'(vecs[i].exp_phase));
      check($sformatf("vec%0d.ped_ack", i), 32'(ped_ack), 32'(vecs[i].exp_ack));
      check($sformatf("vec%0d.lamps", i), 32'({ra, ga, ya, rb, gb, yb, walk}),
            32'(lamps_of(vecs[i].exp_phase)));
    end

    // A rests on green for 100 ticks with only its own traffic.
    step(1,0,1,0,0);
    for (int e = 0; e < 100; e++) begin
      step(0,1,1,0,0);
      check("rest_a.phase", 32'(phase), 32'd0);
    end

    // Tick every 4th cycle: durations scale by four, nothing moves without a tick.
    step(1,0,0,1,0);
    first_y = -1; first_ar = -1; first_gb = -1; bad_hold = 0;
    prev_phase = 0;
    for (int e = 1; e <= 60; e++) begin
      step(0, (e % 4 == 0), 0, 1, 0);
      if ((e % 4 != 0) && (int'(phase) != prev_phase)) bad_hold++;
      if (phase == 3'd1 && first_y  < 0) first_y  = e;
      if (phase == 3'd2 && first_ar < 0) first_ar = e;
      if (phase == 3'd3 && first_gb < 0) first_gb = e;
      prev_phase = int'(phase);
    end
    check("slow.yellow_edge", 32'(first_y), 32'd32);
    check("slow.allred_edge", 32'(first_ar), 32'd44);
    check("slow.green_b_edge", 32'(first_gb), 32'd52);
    check("slow.no_change_without_tick", 32'(bad_hold), 32'd0);

`ifdef TLC_FLASH_EN
    // Flash for 10 ticks, then ALLRED_B for 2 ticks and back to GREEN_A.
    model_en = 1'b0;
    flash = 1'b1;
    step(0,1,1,1,0);
    check("flash.enter", 32'(phase), 32'd7);
    toggles = 0; rb_bad = 0; prev_ya = ya;
    for (int e = 0; e < 10; e++) begin
      step(0,1,1,1,1);
      if (ya != prev_ya) toggles++;
      if (rb != ~ya || ra || ga || gb || yb || ped_ack) rb_bad++;
      prev_ya = ya;
    end
    check("flash.ya_toggles", 32'(toggles), 32'd10);
    check("flash.lamps", 32'(rb_bad), 32'd0);
    flash = 1'b0;
    step(0,1,1,1,0);
    check("flash.exit_allred_b", 32'(phase), 32'd5);
    step(0,1,1,1,0);
    check("flash.allred_hold", 32'(phase), 32'd5);
    step(0,1,1,1,0);
    check("flash.green_a", 32'(phase), 32'd0);
    step(1,0,0,0,0);
    model_en = 1'b1;
`else
    toggles = 0; rb_bad = 0; prev_ya = 1'b0;
`endif

    // Randomized traffic, pedestrians, tick gaps and rare resets vs the model.
    step(1,0,0,0,0);
    for (int e = 0; e < 4000; e++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
